// File: rtl/sseg_scan_driver.sv
// ---------------------------------------------------------------------------
// sseg_scan_driver
//
// Time-multiplexed driver for a 4-digit common-anode seven-segment display
// (M.SS.D layout, d3 leftmost). Each digit owns a slot of REFRESH_DVSR clk
// cycles; within a slot the anode is lit for a fraction of the slot set by
// 'bright', giving eight PWM brightness levels. Digit values and decimal
// points are captured once per frame so a frame never mixes old and new data.
//
// Parameters
//   REFRESH_DVSR  clk cycles per digit slot (legal range 8 .. 2^20)
//
// Ports
//   clk         system clock, rising edge
//   clr         synchronous active-high reset
//   en          1 = scan runs, 0 = scan frozen and display dark
//   d3..d0      BCD digits (values 10..15 show a dash)
//   dp_in       decimal-point request, bit i = digit i, 1 = lit
//   lz_en       1 = blank digit 3 when its captured value is zero
//   bright      brightness level 0..7
//   an          digit anodes, active-low, an[i] = digit i
//   sseg        segments a..g on bits 0..6, active-low
//   dp          decimal point, active-low
//   frame_tick  one-cycle pulse in the cycle after each snapshot load
// ---------------------------------------------------------------------------
module sseg_scan_driver #(
    parameter int REFRESH_DVSR = 100000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic [3:0] dp_in,
    input  logic       lz_en,
    input  logic [2:0] bright,
    output logic [3:0] an,
    output logic [6:0] sseg,
    output logic       dp,
    output logic       frame_tick
);

    // Counter width holds 0..REFRESH_DVSR-1; one extra bit is used for the
    // brightness threshold, which can reach 8*floor(REFRESH_DVSR/8).
    localparam int CW = (REFRESH_DVSR > 1) ? $clog2(REFRESH_DVSR) : 1;
    localparam int SLOT8 = REFRESH_DVSR / 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DVSR - 1);
    localparam logic [CW:0]   SLOT8_W  = (CW + 1)'(SLOT8);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [3:0]    r_snap [4];
    logic [3:0]    r_sdp;

    logic [3:0]    r_an;
    logic [6:0]    r_sseg;
    logic          r_dp;
    logic          r_frame_tick;

    logic          w_last;
    logic          w_load;
    logic [3:0]    w_level;
    logic [CW:0]   w_limit;
    logic          w_in_window;
    logic          w_blank;
    logic          w_active;
    logic [3:0]    w_digit;
    logic [6:0]    w_seg;
    logic [3:0]    w_an_sel;

    assign w_last = (r_cnt == CNT_LAST);
    // Snapshot only at the very end of the digit-3 slot: the whole next frame
    // is then drawn from one consistent set of values.
    assign w_load = en && w_last && (r_idx == 2'd3);

    // Lit window of the slot: (bright+1) eighths, rounded down per eighth so
    // the REFRESH_DVSR mod 8 tail cycles stay dark even at full brightness.
    assign w_level     = {1'b0, bright} + 4'd1;
    assign w_limit     = (CW + 1)'(w_level) * SLOT8_W;
    assign w_in_window = ({1'b0, r_cnt} < w_limit);

    // Leading-zero suppression applies to the leftmost digit only.
    assign w_blank  = lz_en && (r_idx == 2'd3) && (r_snap[3] == 4'd0);
    assign w_active = en && w_in_window && !w_blank;

    assign w_digit  = r_snap[r_idx];
    assign w_an_sel = 4'b0001 << r_idx;

    always_comb begin
        w_seg = 7'h3F;
        case (w_digit)
            4'd0:    w_seg = 7'h40;
            4'd1:    w_seg = 7'h79;
            4'd2:    w_seg = 7'h24;
            4'd3:    w_seg = 7'h30;
            4'd4:    w_seg = 7'h19;
            4'd5:    w_seg = 7'h12;
            4'd6:    w_seg = 7'h02;
            4'd7:    w_seg = 7'h78;
            4'd8:    w_seg = 7'h00;
            4'd9:    w_seg = 7'h10;
            default: w_seg = 7'h3F;
        endcase
    end

    // Scan position: frozen while en=0, resumes from the held position.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (en) begin
            if (w_last) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Frame snapshot of digits and decimal points.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                r_snap[i] <= 4'd0;
            end
            r_sdp <= 4'd0;
        end else if (w_load) begin
            r_snap[0] <= d0;
            r_snap[1] <= d1;
            r_snap[2] <= d2;
            r_snap[3] <= d3;
            r_sdp     <= dp_in;
        end
    end

    // Registered outputs: one cycle behind the scan position they describe.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_an         <= 4'b1111;
            r_sseg       <= 7'h7F;
            r_dp         <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_load;
            if (w_active) begin
                r_an   <= ~w_an_sel;
                r_sseg <= w_seg;
                r_dp   <= ~r_sdp[r_idx];
            end else begin
                r_an   <= 4'b1111;
                r_sseg <= 7'h7F;
                r_dp   <= 1'b1;
            end
        end
    end

    assign an         = r_an;
    assign sseg       = r_sseg;
    assign dp         = r_dp;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_sseg_scan_driver
//
// Directed bench. u_dut8 (REFRESH_DVSR=8) carries the scan, snapshot,
// blanking, decimal-point, freeze and reset checks. u_dut16 and u_dut10
// share the same inputs and are used for brightness duty-cycle counts.
// k numbers the clock edges since the first edge with clr low; the outputs
// seen after edge k describe cnt = k mod 8, idx = (k/8) mod 4 while the
// scan runs uninterrupted.
// ---------------------------------------------------------------------------
module tb_sseg_scan_driver;

    logic       clk = 1'b0;
    logic       clr;
    logic       en;
    logic [3:0] d3, d2, d1, d0;
    logic [3:0] dp_in;
    logic       lz_en;
    logic [2:0] bright;

    logic [3:0] an8, an16, an10;
    logic [6:0] sseg8, sseg16, sseg10;
    logic       dp8, dp16, dp10;
    logic       ft8, ft16, ft10;

    int errors = 0;
    int checks = 0;
    int k = 0;

    always #5 clk = ~clk;

    sseg_scan_driver #(.REFRESH_DVSR(8)) u_dut8 (
        .clk(clk), .clr(clr), .en(en),
        .d3(d3), .d2(d2), .d1(d1), .d0(d0),
        .dp_in(dp_in), .lz_en(lz_en), .bright(bright),
        .an(an8), .sseg(sseg8), .dp(dp8), .frame_tick(ft8)
    );

    sseg_scan_driver #(.REFRESH_DVSR(16)) u_dut16 (
        .clk(clk), .clr(clr), .en(en),
        .d3(d3), .d2(d2), .d1(d1), .d0(d0),
        .dp_in(dp_in), .lz_en(lz_en), .bright(bright),
        .an(an16), .sseg(sseg16), .dp(dp16), .frame_tick(ft16)
    );

    sseg_scan_driver #(.REFRESH_DVSR(10)) u_dut10 (
        .clk(clk), .clr(clr), .en(en),
        .d3(d3), .d2(d2), .d1(d1), .d0(d0),
        .dp_in(dp_in), .lz_en(lz_en), .bright(bright),
        .an(an10), .sseg(sseg10), .dp(dp10), .frame_tick(ft10)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    function automatic logic [3:0] exp_an(input int i);
        logic [3:0] v;
        v = 4'b1111;
        v[i] = 1'b0;
        return v;
    endfunction

    logic [6:0] seg_1234 [4];
    int lows16, lows10;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        seg_1234[0] = 7'h79;
        seg_1234[1] = 7'h24;
        seg_1234[2] = 7'h30;
        seg_1234[3] = 7'h19;

        clr = 1'b1; en = 1'b1;
        d3 = 4'd0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd0;
        dp_in = 4'd0; lz_en = 1'b0; bright = 3'd7;
        k = -100;
        step();
        step();
        check("reset_an", an8, 4'hF);
        check("reset_sseg", sseg8, 7'h7F);
        check("reset_dp", dp8, 1'b1);
        check("reset_ft", ft8, 1'b0);

        // Release reset: zero snapshot shows as digit 0 = '0'.
        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
        clr = 1'b0;
        k = -1;
        step();
        check("post_clr_an", an8, 4'hE);
        check("post_clr_sseg", sseg8, 7'h40);
        check("post_clr_dp", dp8, 1'b1);

        // First frame: anode rotation, frame_tick at the snapshot edge.
        for (int j = 1; j <= 31; j++) begin
            step();
            check($sformatf("f1_an_k%0d", k), an8, exp_an((k / 8) % 4));
            check($sformatf("f1_ft_k%0d", k), ft8, (k == 31));
        end

        // Second frame: captured 1,2,3,4 shown; next tick 32 edges later.
        for (int j = 32; j <= 63; j++) begin
            step();
            if (k % 8 == 2)
                check($sformatf("f2_sseg_k%0d", k), sseg8, seg_1234[(k / 8) % 4]);
            check($sformatf("f2_ft_k%0d", k), ft8, (k == 63));
        end

        // Mid-frame change of d0 must not tear the frame.
        d0 = 4'd5;
        run_to(65);  check("d0_old_1", sseg8, 7'h79);
        run_to(97);  check("d0_5", sseg8, 7'h12);
        run_to(100); d0 = 4'd6;
        run_to(102); check("d0_still_5", sseg8, 7'h12);
        run_to(129); check("d0_6", sseg8, 7'h02);

        // Leading-zero blanking and dash decode.
        d3 = 4'd0; d1 = 4'hC; lz_en = 1'b1;
        run_to(170); check("dash_d1", sseg8, 7'h3F);
        run_to(186);
        check("lz_an", an8, 4'hF);
        check("lz_sseg", sseg8, 7'h7F);
        check("lz_dp", dp8, 1'b1);
        lz_en = 1'b0;
        run_to(189);
        check("nolz_an", an8, 4'h7);
        check("nolz_sseg", sseg8, 7'h40);

        // Decimal points on digits 1 and 2.
        dp_in = 4'b0110;
        run_to(194); check("dp_d0", dp8, 1'b1);
        run_to(202); check("dp_d1", dp8, 1'b0);
        run_to(210); check("dp_d2", dp8, 1'b0);
        run_to(218); check("dp_d3", dp8, 1'b1);

        // Freeze for 20 edges while in the digit-3 slot (cnt=5 held).
        run_to(220);
        en = 1'b0;
        for (int j = 0; j < 20; j++) begin
            step();
            check($sformatf("frz_an_k%0d", k), an8, 4'hF);
            check($sformatf("frz_ft_k%0d", k), ft8, 1'b0);
        end
        check("frz_sseg", sseg8, 7'h7F);
        en = 1'b1;
        step(); check("resume_an", an8, 4'h7);
        check("resume_sseg", sseg8, 7'h40);
        step(); check("resume_ft0", ft8, 1'b0);
        step(); check("resume_ft1", ft8, 1'b1);
        step(); check("resume_idx0_an", an8, 4'hE);
        check("resume_idx0_sseg", sseg8, 7'h02);

        // Reset in the digit-2 slot with en toggling.
        run_to(261); check("pre_clr_an", an8, 4'hB);
        clr = 1'b1; en = 1'b0;
        step();
        check("clr_an", an8, 4'hF);
        check("clr_sseg", sseg8, 7'h7F);
        check("clr_dp", dp8, 1'b1);
        check("clr_ft", ft8, 1'b0);
        en = 1'b1;
        step();
        check("clr_hold_an", an8, 4'hF);
        clr = 1'b0;
        step();
        check("restart_an", an8, 4'hE);
        check("restart_sseg", sseg8, 7'h40);
        check("restart_dp", dp8, 1'b1);
        run_to(294); check("restart_ft0", ft8, 1'b0);
        step();      check("restart_ft1", ft8, 1'b1);
        step();      check("restart_snap_sseg", sseg8, 7'h02);

        // Brightness duty cycles.
        bright = 3'd1;
        step();
        lows16 = 0;
        for (int j = 0; j < 16; j++) begin
            step();
            if (an16 != 4'hF) lows16++;
        end
        check("bright1_dvsr16", lows16, 4);

        bright = 3'd0;
        step();
        lows16 = 0;
        for (int j = 0; j < 16; j++) begin
            step();
            if (an16 != 4'hF) lows16++;
        end
        check("bright0_dvsr16", lows16, 2);

        bright = 3'd7;
        step();
        lows16 = 0;
        lows10 = 0;
        for (int j = 0; j < 16; j++) begin
            step();
            if (an16 != 4'hF) lows16++;
            if (j < 10 && an10 != 4'hF) lows10++;
        end
        check("bright7_dvsr16", lows16, 16);
        check("bright7_dvsr10", lows10, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
